// File: rtl/formula_1_distributor_if.sv
// formula_1_distributor_if: argument/result stream plus broadcast worker bus for the formula-1 distributor
interface formula_1_distributor_if #(parameter int N_WORKERS = 4);
  logic arg_vld, arg_rdy, res_vld;
  logic [31:0] a, b, c, res, w_a, w_b, w_c;
  logic [N_WORKERS-1:0] w_arg_vld, w_res_vld;
  logic [32*N_WORKERS-1:0] w_res;
  modport master(
    input arg_vld, a, b, c, w_res_vld, w_res,
    output arg_rdy, res_vld, res, w_arg_vld, w_a, w_b, w_c
  );
  modport slave(
    output arg_vld, a, b, c, w_res_vld, w_res,
    input arg_rdy, res_vld, res, w_arg_vld, w_a, w_b, w_c
  );
endinterface

// File: rtl/formula_1_distributor.sv
// formula_1_distributor: round-robin dispatch to formula-1 workers with in-order result collection; FORMULA_1_DISTRIBUTOR_ERR_EN adds a sticky spurious-strobe flag
module formula_1_distributor #(
  parameter int N_WORKERS = 4,
  parameter int PTR_W = $clog2(N_WORKERS)
) (
  input logic clk,
  input logic rst,
  formula_1_distributor_if.master bus
`ifdef FORMULA_1_DISTRIBUTOR_ERR_EN
  ,
  output logic err
`endif
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} slot_t;
  slot_t st [N_WORKERS];
  slot_t st_nxt [N_WORKERS];
  logic [31:0] hold [N_WORKERS];
  logic [PTR_W-1:0] issue_ptr, collect_ptr;
  logic dispatch, bypass, held;
  logic [N_WORKERS-1:0] busy, cap;
  function automatic logic [PTR_W-1:0] inc(input logic [PTR_W-1:0] p);
    return p == PTR_W'(N_WORKERS - 1) ? '0 : p + 1'b1;
  endfunction
  always_comb begin
    st_nxt = st;
    busy = '0;
    for (int i = 0; i < N_WORKERS; i++) busy[i] = st[i] == BUSY;
    cap = bus.w_res_vld & busy;
    bus.arg_rdy = st[issue_ptr] == IDLE;
    dispatch = bus.arg_vld && bus.arg_rdy;
    bypass = cap[collect_ptr];
    held = st[collect_ptr] == DONE;
    for (int i = 0; i < N_WORKERS; i++) if (cap[i]) st_nxt[i] = DONE;
    // collect and dispatch never touch the same slot: one needs IDLE, the other BUSY/DONE
    if (bypass || held) st_nxt[collect_ptr] = IDLE;
    if (dispatch) st_nxt[issue_ptr] = BUSY;
    bus.w_arg_vld = dispatch ? N_WORKERS'(1) << issue_ptr : '0;
    bus.w_a = dispatch ? bus.a : '0;
    bus.w_b = dispatch ? bus.b : '0;
    bus.w_c = dispatch ? bus.c : '0;
  end
  always_ff @(posedge clk)
    if (rst) begin
      for (int i = 0; i < N_WORKERS; i++) begin
        st[i] <= IDLE;
        hold[i] <= '0;
      end
      issue_ptr <= '0;
      collect_ptr <= '0;
      bus.res_vld <= 1'b0;
      bus.res <= '0;
    end else begin
      st <= st_nxt;
      for (int i = 0; i < N_WORKERS; i++)
        if (cap[i] && !(bypass && PTR_W'(i) == collect_ptr)) hold[i] <= bus.w_res[32*i +: 32];
      if (dispatch) issue_ptr <= inc(issue_ptr);
      if (bypass || held) collect_ptr <= inc(collect_ptr);
      bus.res_vld <= bypass || held;
      if (bypass) bus.res <= bus.w_res[32*collect_ptr +: 32];
      else if (held) bus.res <= hold[collect_ptr];
    end
`ifdef FORMULA_1_DISTRIBUTOR_ERR_EN
  always_ff @(posedge clk) err <= rst ? 1'b0 : err | (|(bus.w_res_vld & ~busy));
`endif
endmodule

// File: tb/tb_formula_1_distributor.sv
// tb_formula_1_distributor: scoreboard bench with behavioural workers; instance 0 has 4 workers, instance 1 has 3
module tb_formula_1_distributor;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;
  int total = 0, bad = 0, cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  logic av [2];
  logic [31:0] aa [2], ab [2], ac [2];
  logic rdy [2], rv [2];
  logic [31:0] rs [2];
  logic [3:0] wv [2];
  logic [3:0] inj_v [2];
  logic [31:0] inj_d [2];
  int lat [2][4];
  logic [31:0] exp_q [2][$];
  logic [31:0] res_log [2][$];
  int res_cyc [2][$];
  int disp_q [2][$];
  int dcyc [2][$];
`ifdef FORMULA_1_DISTRIBUTOR_ERR_EN
  logic err [2];
`endif
  function automatic logic [31:0] isq(input logic [31:0] x);
    longint r = 0;
    while ((r + 1) * (r + 1) <= longint'(x)) r++;
    return 32'(r);
  endfunction
  function automatic logic [31:0] f1(input logic [31:0] x, y, z);
    return isq(x) + isq(y) + isq(z);
  endfunction
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, want);
    end
  endtask
  for (genvar g = 0; g < 2; g++) begin : cfg
    localparam int N = g ? 3 : 4;
    formula_1_distributor_if #(.N_WORKERS(N)) bus();
    formula_1_distributor #(.N_WORKERS(N)) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
`ifdef FORMULA_1_DISTRIBUTOR_ERR_EN
      ,
      .err(err[g])
`endif
    );
    assign bus.arg_vld = av[g];
    assign bus.a = aa[g];
    assign bus.b = ab[g];
    assign bus.c = ac[g];
    assign rdy[g] = bus.arg_rdy;
    assign rv[g] = bus.res_vld;
    assign rs[g] = bus.res;
    assign wv[g] = 4'(bus.w_arg_vld);
    bit pend [N];
    int due [N];
    logic [31:0] val [N];
    logic [N-1:0] sv;
    logic [32*N-1:0] sd;
    initial begin
      bus.w_res_vld = '0;
      bus.w_res = '0;
    end
    // behavioural workers: strobe at negedge+1, observe dispatch and scoreboard pushes at negedge+2
    always begin
      @(negedge clk);
      #1;
      sv = '0;
      sd = '0;
      for (int i = 0; i < N; i++) begin
        if (pend[i] && due[i] == cyc) begin
          sv[i] = 1'b1;
          sd[32*i +: 32] = val[i];
          pend[i] = 1'b0;
        end
        if (inj_v[g][i]) begin
          sv[i] = 1'b1;
          sd[32*i +: 32] = inj_d[g];
        end
      end
      bus.w_res_vld = sv;
      bus.w_res = sd;
      #1;
      for (int i = 0; i < N; i++)
        if (bus.w_arg_vld[i]) begin
          pend[i] = 1'b1;
          due[i] = cyc + (lat[g][i] > 0 ? lat[g][i] : int'($urandom_range(1, 8)));
          val[i] = f1(bus.w_a, bus.w_b, bus.w_c);
          disp_q[g].push_back(i);
          dcyc[g].push_back(cyc);
        end
      if (!rst) begin
        if (av[g] && rdy[g]) begin
          exp_q[g].push_back(f1(aa[g], ab[g], ac[g]));
          chk("wvld_onehot", 64'($countones(bus.w_arg_vld)), 1);
        end else chk("wvld_idle", 64'(bus.w_arg_vld), 0);
      end
    end
    always @(negedge clk)
      if (bus.res_vld) begin
        res_cyc[g].push_back(cyc);
        res_log[g].push_back(bus.res);
        if (exp_q[g].size() == 0) begin
          total++;
          bad++;
          $display("FAIL res_extra[%0d]: got res_vld=1 res=%0d want res_vld=0", g, bus.res);
        end else chk("res_order", 64'(bus.res), 64'(exp_q[g].pop_front()));
      end
  end
  task automatic tick();
    @(negedge clk);
    #2;
  endtask
  task automatic send(input int k, input logic [31:0] x, y, z);
    int n = 0;
    @(negedge clk);
    av[k] = 1'b1;
    aa[k] = x;
    ab[k] = y;
    ac[k] = z;
    #1;
    while (!rdy[k] && n < 300) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!rdy[k]) begin
      total++;
      bad++;
      $display("FAIL send_timeout[%0d]: arg_rdy=0 want 1", k);
    end
  endtask
  task automatic idle(input int k);
    @(negedge clk);
    av[k] = 1'b0;
  endtask
  task automatic wait_n(input int k, input int n);
    int t = 0;
    while (res_log[k].size() < n && t < 500) begin
      tick();
      t++;
    end
    chk("wait_res", 64'(res_log[k].size()), 64'(n));
  endtask
  task automatic drain(input int k);
    int t = 0;
    while (exp_q[k].size() > 0 && t < 500) begin
      tick();
      t++;
    end
    chk("drain", 64'(exp_q[k].size()), 0);
  endtask
  function automatic logic [31:0] rnd();
    return $urandom_range(0, 70000);
  endfunction
  initial begin
    int b, db, p, n;
    int want [4];
    int lt [4];
    rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      av[k] = 1'b0;
      aa[k] = '0;
      ab[k] = '0;
      ac[k] = '0;
      inj_v[k] = '0;
      inj_d[k] = '0;
      for (int i = 0; i < 4; i++) lat[k][i] = 5;
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #2;
    for (int k = 0; k < 2; k++) begin
      chk("rst_rdy", 64'(rdy[k]), 1);
      chk("rst_res_vld", 64'(rv[k]), 0);
      chk("rst_res", 64'(rs[k]), 0);
      chk("rst_wvld", 64'(wv[k]), 0);
    end
`ifdef FORMULA_1_DISTRIBUTOR_ERR_EN
    chk("rst_err", 64'(err[0]), 0);
`endif
    b = res_log[0].size();
    db = dcyc[0].size();
    send(0, 16, 9, 4);
    chk("t1_wvld", 64'(wv[0]), 1);
    idle(0);
    wait_n(0, b + 1);
    chk("t1_res", 64'(res_log[0][b]), 9);
    chk("t1_latency", 64'(res_cyc[0][b] - dcyc[0][db]), 6);
    repeat (5) tick();
    chk("t1_single", 64'(res_log[0].size()), 64'(b + 1));
    want = '{9, 5, 12, 3};
    lt = '{10, 7, 4, 1};
    p = dcyc[0].size() % 4;
    for (int j = 0; j < 4; j++) lat[0][(p + j) % 4] = lt[j];
    b = res_log[0].size();
    send(0, 16, 9, 4);
    send(0, 4, 1, 4);
    send(0, 16, 16, 16);
    send(0, 1, 1, 1);
    idle(0);
    wait_n(0, b + 4);
    for (int j = 0; j < 4; j++) chk("t2_res", 64'(res_log[0][b + j]), 64'(want[j]));
    for (int j = 1; j < 4; j++) chk("t2_gap", 64'(res_cyc[0][b + j] - res_cyc[0][b + j - 1]), 1);
    for (int i = 0; i < 4; i++) lat[0][i] = 20;
    p = dcyc[0].size() % 4;
    b = res_log[0].size();
    repeat (4) send(0, rnd(), rnd(), rnd());
    @(negedge clk);
    aa[0] = rnd();
    ab[0] = rnd();
    ac[0] = rnd();
    #1;
    n = 0;
    while (!rdy[0] && n < 100) begin
      chk("stall_wvld", 64'(wv[0]), 0);
      @(negedge clk);
      #1;
      n++;
    end
    chk("stall_slot", 64'(wv[0]), 64'(1 << p));
    chk("stall_cycle", 64'(cyc), 64'(res_log[0].size() > b ? res_cyc[0][b] : -1));
    idle(0);
    drain(0);
    @(negedge clk);
    inj_v[0] = 4'b0100;
    inj_d[0] = 77;
    @(negedge clk);
    inj_v[0] = '0;
    b = res_log[0].size();
    #2;
`ifdef FORMULA_1_DISTRIBUTOR_ERR_EN
    chk("spur_err", 64'(err[0]), 1);
`endif
    repeat (4) tick();
    chk("spur_no_res", 64'(res_log[0].size()), 64'(b));
    for (int i = 0; i < 4; i++) lat[0][i] = 3;
    db = disp_q[0].size();
    repeat (4) send(0, rnd(), rnd(), rnd());
    idle(0);
    drain(0);
    for (int j = 0; j < 4; j++) chk("spur_order", 64'(disp_q[0][db + j]), 64'((disp_q[0][db] + j) % 4));
`ifdef FORMULA_1_DISTRIBUTOR_ERR_EN
    chk("spur_err_sticky", 64'(err[0]), 1);
`endif
    for (int i = 0; i < 4; i++) lat[0][i] = 15;
    repeat (3) send(0, rnd(), rnd(), rnd());
    idle(0);
    repeat (2) tick();
    @(negedge clk);
    rst = 1'b1;
    exp_q[0].delete();
    @(negedge clk);
    rst = 1'b0;
    #2;
    chk("rst_mid_rdy", 64'(rdy[0]), 1);
`ifdef FORMULA_1_DISTRIBUTOR_ERR_EN
    chk("rst_mid_err", 64'(err[0]), 0);
`endif
    b = res_log[0].size();
    repeat (25) tick();
    chk("rst_mid_no_res", 64'(res_log[0].size()), 64'(b));
    chk("rst_mid_rdy2", 64'(rdy[0]), 1);
    send(0, rnd(), rnd(), rnd());
    chk("rst_mid_slot0", 64'(wv[0]), 1);
    idle(0);
    drain(0);
    for (int i = 0; i < 4; i++) lat[0][i] = 0;
    b = res_log[0].size();
    for (int j = 0; j < 40; j++) begin
      send(0, rnd(), rnd(), rnd());
      if ($urandom_range(0, 2) == 0) begin
        idle(0);
        repeat ($urandom_range(1, 3)) tick();
      end
    end
    idle(0);
    drain(0);
    chk("rand_count", 64'(res_log[0].size()), 64'(b + 40));
    for (int i = 0; i < 4; i++) lat[1][i] = 0;
    db = disp_q[1].size();
    b = res_log[1].size();
    repeat (7) send(1, rnd(), rnd(), rnd());
    idle(1);
    drain(1);
    for (int j = 0; j < 7; j++) chk("wrap_worker", 64'(disp_q[1][db + j]), 64'(j % 3));
    chk("wrap_count", 64'(res_log[1].size()), 64'(b + 7));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
